// File: rtl/axi_slave_read_responder.sv
// AXI read-channel slave: accepts one AR burst at a time, walks FIXED/INCR/WRAP
// addresses into a 1-cycle-latency backend and returns R beats via a 2-entry buffer.
module axi_slave_read_responder #(
   parameter int unsigned addr_width     = 32,
   parameter int unsigned data_width     = 64,
   parameter int unsigned mem_addr_width = 16
) (
   input  logic                      AClk,
   input  logic                      ARst,
   input  logic [7:0]                ARID,
   input  logic [addr_width-1:0]     ARADDR,
   input  logic [7:0]                ARLEN,
   input  logic [2:0]                ARSIZE,
   input  logic [1:0]                ARBURST,
   input  logic [1:0]                ARLOCK,
   input  logic [1:0]                ARCACHE,
   input  logic [2:0]                ARPROT,
   input  logic                      ARVALID,
   output logic                      ARREADY,
   output logic [7:0]                RID,
   output logic [data_width-1:0]     RDATA,
   output logic [1:0]                RRESP,
   output logic                      RLAST,
   output logic                      RVALID,
   input  logic                      RREADY,
   output logic                      mem_rd_en,
   output logic [mem_addr_width-1:0] mem_addr,
   input  logic [data_width-1:0]     mem_rdata,
   output logic                      busy
);

   localparam int unsigned BYTES = data_width / 8;
   localparam int unsigned LB    = $clog2(BYTES);

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

   state_t                  state_q, state_d;
   logic                    arready_q, arready_d;
   logic                    busy_q, busy_d;
   logic [7:0]              rid_q, rid_d;
   logic [addr_width-1:0]   addr_q, addr_d;
   logic [7:0]              len_q, len_d;
   logic [2:0]              size_q, size_d;
   logic [1:0]              burst_q, burst_d;
   logic                    err_q, err_d;
   logic [8:0]              rem_q, rem_d;
   logic                    inflight_q, inflight_d;
   logic                    inflight_last_q, inflight_last_d;
   logic [data_width-1:0]   head_data_q, head_data_d, tail_data_q, tail_data_d;
   logic [1:0]              head_resp_q, head_resp_d, tail_resp_q, tail_resp_d;
   logic                    head_last_q, head_last_d, tail_last_q, tail_last_d;
   logic                    head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;

   logic                    pop;
   logic                    slot;
   logic [1:0]              occ;
   logic [data_width-1:0]   wr_data;
   logic [1:0]              wr_resp;
   logic [addr_width-1:0]   step, wrap_mask, incr_addr, next_addr;
   logic [addr_width-1:0]   ar_align_mask;
   logic                    ar_wrap_len_ok, ar_err;
   logic                    unused_sideband;

   assign unused_sideband = ^{ARLOCK, ARCACHE, ARPROT};

   // Next beat address for the captured burst
   always_comb begin
      step      = addr_width'(1) << size_q;
      wrap_mask = ((addr_width'(len_q) + addr_width'(1)) << size_q) - addr_width'(1);
      incr_addr = addr_q + step;
      case (burst_q)
         BURST_INCR: next_addr = incr_addr;
         BURST_WRAP: next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
         default:    next_addr = addr_q;
      endcase
   end

   // Request legality, judged once at capture
   always_comb begin
      ar_align_mask  = (addr_width'(1) << ARSIZE) - addr_width'(1);
      ar_wrap_len_ok = (ARLEN == 8'd1) || (ARLEN == 8'd3) || (ARLEN == 8'd7) || (ARLEN == 8'd15);
      ar_err = (ARBURST == BURST_RSVD) || (32'(ARSIZE) > LB) ||
               ((ARBURST == BURST_WRAP) && (!ar_wrap_len_ok || ((ARADDR & ar_align_mask) != '0)));
   end

   // Issue slots are granted only when the eventual write cannot overflow the buffer
   always_comb begin
      pop     = head_vld_q & RREADY;
      occ     = 2'(head_vld_q) + 2'(tail_vld_q) + 2'(inflight_q);
      slot    = (state_q == BURST) && ((occ < 2'd2) || ((occ == 2'd2) && pop));
      wr_data = err_q ? '0 : mem_rdata;
      wr_resp = err_q ? RESP_SLVERR : RESP_OKAY;
   end

   // Control FSM next state
   always_comb begin
      state_d         = state_q;
      rid_d           = rid_q;
      addr_d          = addr_q;
      len_d           = len_q;
      size_d          = size_q;
      burst_d         = burst_q;
      err_d           = err_q;
      rem_d           = rem_q;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (ARVALID && arready_q) begin
               rid_d   = ARID;
               addr_d  = ARADDR;
               len_d   = ARLEN;
               size_d  = ARSIZE;
               burst_d = ARBURST;
               err_d   = ar_err;
               rem_d   = 9'(ARLEN) + 9'd1;
               state_d = BURST;
            end
         end
         BURST: begin
            if (slot) begin
               rem_d           = rem_q - 9'd1;
               addr_d          = next_addr;
               inflight_d      = 1'b1;
               inflight_last_d = (rem_q == 9'd1);
               if (rem_q == 9'd1) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head_last_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      arready_d = (state_d == IDLE);
      busy_d    = (state_d != IDLE);
   end

   // Two-entry return buffer; head drives the R channel and reads as zero when empty
   always_comb begin
      head_data_d = head_data_q;
      head_resp_d = head_resp_q;
      head_last_d = head_last_q;
      head_vld_d  = head_vld_q;
      tail_data_d = tail_data_q;
      tail_resp_d = tail_resp_q;
      tail_last_d = tail_last_q;
      tail_vld_d  = tail_vld_q;
      case ({head_vld_q, tail_vld_q})
         2'b00: begin
            if (inflight_q) begin
               head_data_d = wr_data;
               head_resp_d = wr_resp;
               head_last_d = inflight_last_q;
               head_vld_d  = 1'b1;
            end
         end
         2'b10: begin
            if (pop && inflight_q) begin
               head_data_d = wr_data;
               head_resp_d = wr_resp;
               head_last_d = inflight_last_q;
            end else if (pop) begin
               head_data_d = '0;
               head_resp_d = '0;
               head_last_d = 1'b0;
               head_vld_d  = 1'b0;
            end else if (inflight_q) begin
               tail_data_d = wr_data;
               tail_resp_d = wr_resp;
               tail_last_d = inflight_last_q;
               tail_vld_d  = 1'b1;
            end
         end
         2'b11: begin
            if (pop) begin
               head_data_d = tail_data_q;
               head_resp_d = tail_resp_q;
               head_last_d = tail_last_q;
               if (inflight_q) begin
                  tail_data_d = wr_data;
                  tail_resp_d = wr_resp;
                  tail_last_d = inflight_last_q;
               end else begin
                  tail_data_d = '0;
                  tail_resp_d = '0;
                  tail_last_d = 1'b0;
                  tail_vld_d  = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge AClk) begin
      if (!ARst) begin
         state_q         <= IDLE;
         arready_q       <= 1'b0;
         busy_q          <= 1'b0;
         rid_q           <= '0;
         addr_q          <= '0;
         len_q           <= '0;
         size_q          <= '0;
         burst_q         <= BURST_FIXED;
         err_q           <= 1'b0;
         rem_q           <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         head_data_q     <= '0;
         head_resp_q     <= '0;
         head_last_q     <= 1'b0;
         head_vld_q      <= 1'b0;
         tail_data_q     <= '0;
         tail_resp_q     <= '0;
         tail_last_q     <= 1'b0;
         tail_vld_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         arready_q       <= arready_d;
         busy_q          <= busy_d;
         rid_q           <= rid_d;
         addr_q          <= addr_d;
         len_q           <= len_d;
         size_q          <= size_d;
         burst_q         <= burst_d;
         err_q           <= err_d;
         rem_q           <= rem_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         head_data_q     <= head_data_d;
         head_resp_q     <= head_resp_d;
         head_last_q     <= head_last_d;
         head_vld_q      <= head_vld_d;
         tail_data_q     <= tail_data_d;
         tail_resp_q     <= tail_resp_d;
         tail_last_q     <= tail_last_d;
         tail_vld_q      <= tail_vld_d;
      end
   end

   assign ARREADY   = arready_q;
   assign busy      = busy_q;
   assign RID       = rid_q;
   assign RDATA     = head_data_q;
   assign RRESP     = head_resp_q;
   assign RLAST     = head_last_q;
   assign RVALID    = head_vld_q;
   assign mem_rd_en = slot && !err_q;
   assign mem_addr  = mem_addr_width'(addr_q >> LB);

endmodule

// File: doc/axi_slave_read_responder.md
Name: axi_slave_read_responder

Overview:
- AXI slave-side read channel responder: the counterpart of the master read control in the AXI FIFO BFM.
- Accepts one AR request at a time and generates the addresses for FIXED, INCR and WRAP bursts.
- Reads a 1-cycle-latency synchronous memory/FIFO backend and returns the R beats with RLAST, RRESP and RID.
- Sustains one beat per cycle under RREADY backpressure, using a 2-entry output buffer.

Parameters:
- addr_width, 32, AXI byte address width.
- data_width, 64, RDATA width in bits. Legal values are 8 to 1024, powers of two. Derived constants: BYTES = data_width/8, LB = log2(BYTES).
- mem_addr_width, 16, backend word address width.

Ports:
- AClk  in  1  clock; all logic is on the rising edge.
- ARst  in  1  synchronous reset, active-low.
- ARID  in  8  transaction ID.
- ARADDR  in  addr_width  start byte address.
- ARLEN  in  8  beats minus 1.
- ARSIZE  in  3  log2 of bytes per beat.
- ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- ARLOCK  in  2  accepted and ignored.
- ARCACHE  in  2  accepted and ignored.
- ARPROT  in  3  accepted and ignored.
- ARVALID  in  1  address valid.
- ARREADY  out  1  address ready.
- RID  out  8  echo of the captured ARID.
- RDATA  out  data_width  read data.
- RRESP  out  2  00 OKAY, 10 SLVERR.
- RLAST  out  1  marks the final beat.
- RVALID  out  1  data valid.
- RREADY  in  1  master ready.
- mem_rd_en  out  1  backend read strobe.
- mem_addr  out  mem_addr_width  backend word address: current byte address >> LB, truncated.
- mem_rdata  in  data_width  valid the cycle after mem_rd_en.
- busy  out  1  high when the state is not IDLE.

Behaviour:
- Reset (ARst=0 at a clock edge) clears everything; a reset mid-burst abandons the burst with no further beats. Values after reset:
  - ARREADY=0, RVALID=0, RLAST=0, RDATA=0, RRESP=0, RID=0, mem_rd_en=0, busy=0.
  - Buffer empty, in-flight flag clear, state IDLE.
  - ARREADY goes to 1 on the first clock edge with ARst=1.
- IDLE state:
  - ARREADY=1 (registered).
  - On ARVALID&&ARREADY: capture ARID, ARADDR, ARLEN, ARSIZE and ARBURST; remaining=ARLEN+1 (9-bit); move to BURST; ARREADY drops to 0 on the next edge.
- Error classification, made at capture. The burst is flagged err if any of these hold:
  - ARBURST=11;
  - ARSIZE>LB;
  - WRAP with ARLEN not in {1,3,7,15};
  - WRAP with ARADDR not aligned to 1<<ARSIZE.
- BURST state:
  - Issue slot when (buffer_count + inflight) < 2, or when (buffer_count + inflight) = 2 and a beat is handshaking this cycle.
  - At each slot: if not err, assert mem_rd_en for one cycle at the current address; if err, no memory access and the beat is produced as data 0.
  - At each slot: remaining decrements, the address advances, and the slot's last flag = (remaining==1).
  - The issue that drives remaining to 0 moves the state to DRAIN.
- Address advance:
  - FIXED: address unchanged.
  - INCR: addr += 1<<size, wrapping modulo 2^addr_width. No 4 KB check.
  - WRAP: wrap length W = (len+1)<<size. addr = (addr & ~(W-1)) | ((addr + (1<<size)) & (W-1)).
- Return path:
  - The slot result (mem_rdata, or 0 for err) is written into the buffer on the edge after the slot, together with RRESP (OKAY, or SLVERR for err) and RLAST (the slot's last flag).
  - RDATA, RRESP, RLAST and RVALID come from the buffer head register.
  - RID is held constant at the captured ID for the whole burst.
- Latency:
  - AR handshake in cycle T.
  - mem_rd_en first asserted in T+1.
  - RVALID first high in T+3.
  - With RREADY held high, beats appear on consecutive cycles.
- Backpressure:
  - While RVALID=1 and RREADY=0, RDATA, RRESP, RLAST and RID are stable.
  - No beat is lost or duplicated; the buffer never exceeds 2 entries.
  - Simultaneous buffer write and head pop are legal.
- DRAIN state:
  - No issues.
  - On RVALID&&RREADY&&RLAST: move to IDLE, and ARREADY=1 on the following cycle.
  - The minimum gap between AR handshakes is len+4 cycles.
- Outputs when idle: RVALID=0; RDATA, RRESP and RLAST hold 0 after drain.
- Every burst returns exactly ARLEN+1 beats, including error bursts. RLAST is high only on the final one.

Test Plan:
- INCR: ARADDR=0x100, ARLEN=3, ARSIZE=3, RREADY=1 -> mem_addr 0x20,0x21,0x22,0x23 in T+1..T+4; RVALID in T+3..T+6; RLAST only on beat 4; RRESP=00; RID=ARID.
- WRAP: ARADDR=0x118, ARLEN=3, ARSIZE=3 -> byte addresses 0x118,0x100,0x108,0x110 (mem_addr 0x23,0x20,0x21,0x22).
- FIXED: ARADDR=0x40, ARLEN=2 -> mem_addr 0x08 three times; 3 beats returned.
- Backpressure: INCR with ARLEN=7 and RREADY toggling 1,0,0,1 -> outputs stable while stalled; 8 beats in order; buffer never overflows; ARREADY=1 only after the 8th handshake.
- Errors:
  - ARBURST=11, ARLEN=1 -> 2 beats of RDATA=0 and RRESP=10; mem_rd_en never asserted.
  - WRAP with ARLEN=2 -> 3 SLVERR beats.
- Reset: ARst=0 mid-burst after beat 2 -> the next cycle has RVALID=0, ARREADY=0, busy=0. After release, ARREADY=1 and a new burst completes normally.
